// File: rtl/bk16_share_ctrl_pkg.sv
// Shared definitions for the bk16 adder-sharing controller.
//   state_e  : controller FSM states
//   HALF_W   : width of one adder pass (16)
//   FULL_W   : width of a wide operand (32)
//   half_of  : selects the low or high 16-bit half of a 32-bit operand
package bk16_share_ctrl_pkg;

  localparam int HALF_W = 16;
  localparam int FULL_W = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    LO_W = 3'd2,
    HI   = 3'd3,
    HI_W = 3'd4,
    RESP = 3'd5
  } state_e;

  function automatic logic [HALF_W-1:0] half_of(input logic [FULL_W-1:0] word,
                                                input logic              upper);
    return upper ? word[FULL_W-1:HALF_W] : word[HALF_W-1:0];
  endfunction

endpackage

// File: rtl/bk16_rr_pick.sv
// Combinational round-robin picker.
//   req_valid : per-requester valid
//   rr_ptr    : index searched first (always < NREQ)
//   grant     : one-hot grant, zero when nothing is valid
//   grant_idx : index of the granted requester (0 when none)
//   any_valid : at least one requester is valid
module bk16_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_valid
);

  always_comb begin
    int j;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    j         = 0;
    // Walk rr_ptr, rr_ptr+1, ... with wrap; the first valid hit wins.
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any_valid && req_valid[j]) begin
        any_valid = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/bk16_share_ctrl.sv
// Shares one registered 16-bit adder core between NREQ requesters.
// Narrow ops take one adder pass, wide ops take two with the low-pass
// carry chained into the high pass. Results return on one tagged port.
//
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester request handshake
//   req_a, req_b          : 32-bit operands, requester i at [32i+31:32i]
//   req_cin, req_wide     : per-requester carry-in and 32-bit select
//   add_x, add_y, add_cin : registered drive into the adder core
//   add_s                 : adder core registered sum (one cycle behind add_*)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_id, rsp_sum, rsp_cout : response tag, result and final carry
//   busy                  : controller is not in IDLE
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is only offered in IDLE and is at most one-hot;
// rsp_valid stays high with rsp_* stable until rsp_ready takes it.
import bk16_share_ctrl_pkg::*;

module bk16_share_ctrl #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ-1:0]      req_cin,
  input  logic [NREQ-1:0]      req_wide,
  output logic [HALF_W-1:0]    add_x,
  output logic [HALF_W-1:0]    add_y,
  output logic                 add_cin,
  input  logic [HALF_W:0]      add_s,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [FULL_W-1:0]    rsp_sum,
  output logic                 rsp_cout,
  output logic                 busy
);

  state_e              state;
  logic [IDW-1:0]      rr_ptr;
  logic [NREQ-1:0]     pick_grant;
  logic [IDW-1:0]      pick_idx;
  logic                pick_any;
  logic [IDW-1:0]      next_ptr;

  logic [FULL_W-1:0]   sel_a;
  logic [FULL_W-1:0]   sel_b;
  logic                sel_cin;
  logic                sel_wide;

  // Only the high halves need holding; the low halves go straight into
  // add_x/add_y on the grant edge.
  logic [HALF_W-1:0]   op_a_hi;
  logic [HALF_W-1:0]   op_b_hi;
  logic                op_wide;
  logic [HALF_W-1:0]   lo;

  bk16_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_cin  = 1'b0;
    sel_wide = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        sel_a    = sel_a | req_a[FULL_W*i +: FULL_W];
        sel_b    = sel_b | req_b[FULL_W*i +: FULL_W];
        sel_cin  = sel_cin | req_cin[i];
        sel_wide = sel_wide | req_wide[i];
      end
    end
  end

  assign next_ptr = (pick_idx == IDW'(NREQ-1)) ? '0 : pick_idx + IDW'(1);

  // Gated by rst so nothing is accepted while reset is held.
  assign req_ready = (state == IDLE && rst) ? pick_grant : '0;
  assign busy      = (state != IDLE);

  // add_* are loaded on the edge entering LO/HI so the adder registers
  // them at the end of LO/HI and add_s is valid during LO_W/HI_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_a_hi   <= '0;
      op_b_hi   <= '0;
      op_wide   <= 1'b0;
      lo        <= '0;
      add_x     <= '0;
      add_y     <= '0;
      add_cin   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            op_a_hi <= half_of(sel_a, 1'b1);
            op_b_hi <= half_of(sel_b, 1'b1);
            op_wide <= sel_wide;
            rsp_id  <= pick_idx;
            rr_ptr  <= next_ptr;
            add_x   <= half_of(sel_a, 1'b0);
            add_y   <= half_of(sel_b, 1'b0);
            add_cin <= sel_cin;
            state   <= LO;
          end
        end
        LO: state <= LO_W;
        LO_W: begin
          if (op_wide) begin
            lo      <= add_s[HALF_W-1:0];
            add_x   <= op_a_hi;
            add_y   <= op_b_hi;
            add_cin <= add_s[HALF_W];
            state   <= HI;
          end else begin
            rsp_sum   <= {{HALF_W{1'b0}}, add_s[HALF_W-1:0]};
            rsp_cout  <= add_s[HALF_W];
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        HI: state <= HI_W;
        HI_W: begin
          rsp_sum   <= {add_s[HALF_W-1:0], lo};
          rsp_cout  <= add_s[HALF_W];
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
